// File: rtl/seg7_pkg.sv
// Shared types for the sequential multiply/BCD display block: segment
// patterns (gfedcba, active low), FSM state encoding and a pow10 helper.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'b1111111;

  localparam seg7_t SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
  };

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    BCD,
    DONE
  } state_t;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/seq_mul_bcd_display_if.sv
// Handshake/data bundle for seq_mul_bcd_display.
// master: start/op1/op2 out; slave: busy/done/product/seg out.
interface seq_mul_bcd_display_if #(
  parameter int W      = 4,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [W-1:0]          op1;
  logic [W-1:0]          op2;
  logic                  busy;
  logic                  done;
  logic [2*W-1:0]        product;
  logic [7*DIGITS-1:0]   seg;

  modport master (
    output start, op1, op2,
    input  busy, done, product, seg
  );

  modport slave (
    input  start, op1, op2,
    output busy, done, product, seg
  );
endinterface

// File: rtl/seg7_decode.sv
// One BCD digit to active-low 7-segment (gfedcba).
// Ports: bcd (4b in), seg (seg7_t out); codes 10..15 show blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output seg7_t      seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (bcd)
      4'd0: seg = SEG_DIGIT[0];
      4'd1: seg = SEG_DIGIT[1];
      4'd2: seg = SEG_DIGIT[2];
      4'd3: seg = SEG_DIGIT[3];
      4'd4: seg = SEG_DIGIT[4];
      4'd5: seg = SEG_DIGIT[5];
      4'd6: seg = SEG_DIGIT[6];
      4'd7: seg = SEG_DIGIT[7];
      4'd8: seg = SEG_DIGIT[8];
      4'd9: seg = SEG_DIGIT[9];
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seq_mul_bcd_display.sv
// Sequential shift-add multiplier, double-dabble BCD, registered 7-seg out.
// Ports: clk, rst (async high), bus (slave: start/op1/op2 in;
// busy/done/product/seg out). Macro LEAD_ZERO_BLANK_EN blanks leading zeros.
module seq_mul_bcd_display
  import seg7_pkg::*;
#(
  parameter int W      = 4,
  parameter int DIGITS = 3
) (
  input logic                 clk,
  input logic                 rst,
  seq_mul_bcd_display_if.slave bus
);

  localparam int PW = 2 * W;
  localparam int BW = 4 * DIGITS;
  localparam int SW = 7 * DIGITS;
  localparam int CW = $clog2(PW + 1);

`ifdef LEAD_ZERO_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  localparam longint unsigned OP_MAX = (64'd1 << W) - 64'd1;

  if (OP_MAX * OP_MAX > pow10(DIGITS) - 64'd1) begin : g_chk
    $error("DIGITS too small for W-bit product");
  end

  function automatic logic [SW-1:0] seg_rst();
    logic [SW-1:0] r;
    for (int i = 0; i < DIGITS; i++)
      r[7*i +: 7] = (i == 0 || !BLANK_EN) ? SEG_DIGIT[0] : SEG_BLANK;
    return r;
  endfunction

  localparam logic [SW-1:0] SEG_RST = seg_rst();

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  cnt;
  logic [PW-1:0]  mcand;
  logic [W-1:0]   mplier;
  logic [PW-1:0]  acc;
  logic [PW-1:0]  acc_nxt;
  logic [PW-1:0]  pshift;
  logic [BW-1:0]  bcd;
  logic [BW-1:0]  bcd_adj;
  logic [BW-1:0]  bcd_nxt;
  logic [PW-1:0]  product_q;
  logic [SW-1:0]  seg_q;
  logic [SW-1:0]  seg_dec;
  logic [SW-1:0]  seg_nxt;
  logic           mul_last;
  logic           bcd_last;

  assign mul_last = (cnt == CW'(W - 1));
  assign bcd_last = (cnt == CW'(PW - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.start) state_nxt = MUL;
      MUL:  if (mul_last)  state_nxt = BCD;
      BCD:  if (bcd_last)  state_nxt = DONE;
      DONE: state_nxt = IDLE;
    endcase
  end

  assign acc_nxt = mplier[0] ? acc + mcand : acc;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  assign bcd_nxt = {bcd_adj[BW-2:0], pshift[PW-1]};

  // Decode the value the BCD register is about to take so the
  // final conversion step and the seg load share one edge.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .bcd (bcd_nxt[4*g +: 4]),
      .seg (seg_dec[7*g +: 7])
    );
  end

  assign seg_nxt[6:0] = seg_dec[6:0];

  for (genvar g = 1; g < DIGITS; g++) begin : g_blank
    logic keep;
    assign keep = |bcd_nxt[BW-1:4*g];
    assign seg_nxt[7*g +: 7] =
      (BLANK_EN && !keep) ? SEG_BLANK : seg_dec[7*g +: 7];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      pshift    <= '0;
      bcd       <= '0;
      product_q <= '0;
      seg_q     <= SEG_RST;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= PW'(bus.op1);
            mplier <= bus.op2;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (mul_last) begin
            cnt    <= '0;
            pshift <= acc_nxt;
            bcd    <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        BCD: begin
          bcd    <= bcd_nxt;
          pshift <= pshift << 1;
          if (bcd_last) begin
            cnt       <= '0;
            product_q <= acc;
            seg_q     <= seg_nxt;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
        end
      endcase
    end
  end

  assign bus.busy    = (state == MUL) || (state == BCD);
  assign bus.done    = (state == DONE);
  assign bus.product = product_q;
  assign bus.seg     = seg_q;

endmodule

// File: tb/tb_seq_mul_bcd_display.sv
// Bench for seq_mul_bcd_display: W=4/DIGITS=3 and W=8/DIGITS=5 instances,
// arithmetic reference model checked every cycle plus literal vectors.
module tb_seq_mul_bcd_display;

  localparam logic [6:0] PAT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
  };
  localparam logic [6:0] BL = 7'b1111111;

`ifdef LEAD_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  localparam int WW [2] = '{4, 8};
  localparam int ND [2] = '{3, 5};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] st = '0;
  logic [7:0] oa [2];
  logic [7:0] ob [2];

  logic        busy_v [2];
  logic        done_v [2];
  logic [15:0] prod_v [2];
  logic [34:0] seg_v  [2];

  seq_mul_bcd_display_if #(.W(4), .DIGITS(3)) if4 ();
  seq_mul_bcd_display_if #(.W(8), .DIGITS(5)) if8 ();

  assign if4.start = st[0];
  assign if4.op1   = oa[0][3:0];
  assign if4.op2   = ob[0][3:0];
  assign if8.start = st[1];
  assign if8.op1   = oa[1];
  assign if8.op2   = ob[1];

  assign busy_v[0] = if4.busy;
  assign done_v[0] = if4.done;
  assign prod_v[0] = {8'h00, if4.product};
  assign seg_v[0]  = {14'h3fff, if4.seg};
  assign busy_v[1] = if8.busy;
  assign done_v[1] = if8.done;
  assign prod_v[1] = if8.product;
  assign seg_v[1]  = if8.seg;

  seq_mul_bcd_display #(.W(4), .DIGITS(3)) u4 (
    .clk (clk), .rst (rst), .bus (if4.slave)
  );
  seq_mul_bcd_display #(.W(8), .DIGITS(5)) u8 (
    .clk (clk), .rst (rst), .bus (if8.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected display for value v on nd digits; unused high bits are 1.
  function automatic logic [34:0] exp_seg(input longint unsigned v,
                                          input int nd);
    logic [34:0] r;
    longint unsigned p;
    r = '1;
    p = 1;
    for (int i = 0; i < nd; i++) begin
      if (LZB && i > 0 && (v / p) == 0) r[7*i +: 7] = BL;
      else r[7*i +: 7] = PAT[(v / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  // Reference model: mt = cycles since accepted start (-1 when idle).
  int              mt    [2];
  longint unsigned ma    [2];
  longint unsigned mb    [2];
  logic [15:0]     mprod [2];
  logic [34:0]     mseg  [2];
  bit              armed = 1'b0;

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mt[d]    = -1;
        mprod[d] = '0;
        mseg[d]  = exp_seg(0, ND[d]);
      end else if (mt[d] < 0) begin
        if (st[d]) begin
          mt[d] = 0;
          ma[d] = oa[d];
          mb[d] = ob[d];
        end
      end else begin
        mt[d]++;
        if (mt[d] == 3 * WW[d]) begin
          mprod[d] = 16'(ma[d] * mb[d]);
          mseg[d]  = exp_seg(ma[d] * mb[d], ND[d]);
        end else if (mt[d] > 3 * WW[d]) begin
          mt[d] = -1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed && !rst) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("u%0d busy", d), 64'(busy_v[d]),
            64'(mt[d] >= 0 && mt[d] < 3 * WW[d]));
        chk($sformatf("u%0d done", d), 64'(done_v[d]),
            64'(mt[d] == 3 * WW[d]));
        chk($sformatf("u%0d product", d), 64'(prod_v[d]), 64'(mprod[d]));
        chk($sformatf("u%0d seg", d), 64'(seg_v[d]), 64'(mseg[d]));
      end
    end
  end

  // Pulse start for one cycle, return cycles until done (start cycle = 0).
  task automatic op(input int d, input int a, input int b, output int lat);
    @(negedge clk);
    st[d] = 1'b1;
    oa[d] = 8'(a);
    ob[d] = 8'(b);
    @(negedge clk);
    st[d] = 1'b0;
    lat = 1;
    while (!done_v[d] && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 60) begin
      n_chk++;
      n_err++;
      $display("FAIL timeout u%0d: no done after %0d cycles", d, lat);
    end
  endtask

  localparam logic [20:0] RST3 = LZB ? {BL, BL, PAT[0]} : {3{PAT[0]}};

  int lat;
  int dcnt;
  int bcnt;

  initial begin
    oa[0] = '0; ob[0] = '0; oa[1] = '0; ob[1] = '0;
    #1 rst = 1'b1;
    #3;
    chk("reset busy", 64'(if4.busy), 64'd0);
    chk("reset done", 64'(if4.done), 64'd0);
    chk("reset product", 64'(if4.product), 64'd0);
    chk("reset seg", 64'(if4.seg), 64'(RST3));
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    armed = 1'b1;

    // 15 x 15 = 225
    op(0, 15, 15, lat);
    chk("t1 latency", 64'(lat), 64'd13);
    chk("t1 product", 64'(if4.product), 64'd225);
    chk("t1 seg", 64'(if4.seg), 64'({7'b0100100, 7'b0100100, 7'b0010010}));

    // 7 x 8 = 56
    op(0, 7, 8, lat);
    chk("t2 product", 64'(if4.product), 64'd56);
    chk("t2 seg", 64'(if4.seg),
        64'({LZB ? BL : 7'b1000000, 7'b0010010, 7'b0000010}));

    // 0 x 9: no early exit
    op(0, 0, 9, lat);
    chk("t3 latency", 64'(lat), 64'd13);
    chk("t3 product", 64'(if4.product), 64'd0);
    chk("t3 seg", 64'(if4.seg), 64'(RST3));

    // Starts while busy and in DONE are dropped; cycle 14 is accepted
    @(negedge clk);
    st[0] = 1'b1; oa[0] = 8'd3; ob[0] = 8'd3;
    dcnt = 0;
    for (int c = 1; c <= 27; c++) begin
      @(negedge clk);
      st[0] = (c == 4 || c == 13 || c == 14);
      if (c != 1) begin oa[0] = 8'd5; ob[0] = 8'd5; end
      if (done_v[0]) dcnt++;
      if (c == 13) begin
        chk("t4 done c13", 64'(if4.done), 64'd1);
        chk("t4 product", 64'(if4.product), 64'd9);
        chk("t4 single done", 64'(dcnt), 64'd1);
      end
    end
    st[0] = 1'b0;
    chk("t4 second done", 64'(if4.done), 64'd1);
    chk("t4 product2", 64'(if4.product), 64'd25);
    chk("t4 done count", 64'(dcnt), 64'd2);

    // Reset in the middle of MUL
    @(negedge clk);
    st[0] = 1'b1; oa[0] = 8'd12; ob[0] = 8'd11;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      st[0] = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    chk("t5 busy", 64'(if4.busy), 64'd0);
    chk("t5 done", 64'(if4.done), 64'd0);
    chk("t5 product", 64'(if4.product), 64'd0);
    chk("t5 seg", 64'(if4.seg), 64'(RST3));
    @(negedge clk);
    #2 rst = 1'b0;
    op(0, 2, 3, lat);
    chk("t5 product after", 64'(if4.product), 64'd6);

    // W=8: 255 x 255 = 65025
    @(negedge clk);
    st[1] = 1'b1; oa[1] = 8'd255; ob[1] = 8'd255;
    bcnt = 0;
    lat = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      st[1] = 1'b0;
      if (busy_v[1]) bcnt++;
      if (done_v[1] && lat == 0) lat = c;
    end
    chk("t6 latency", 64'(lat), 64'd25);
    chk("t6 busy cycles", 64'(bcnt), 64'd24);
    chk("t6 product", 64'(if8.product), 64'd65025);
    chk("t6 seg", 64'(if8.seg), 64'({7'b0000010, 7'b0010010, 7'b1000000,
                                     7'b0100100, 7'b0010010}));

    // W=8: 3 x 4 = 12 exercises leading-zero handling on 5 digits
    op(1, 3, 4, lat);
    chk("t7 latency", 64'(lat), 64'd25);
    chk("t7 seg", 64'(if8.seg),
        64'({LZB ? {3{BL}} : {3{7'b1000000}}, 7'b1111001, 7'b0100100}));

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_mul_bcd_display.md
Name: seq_mul_bcd_display

Overview:
Parametrised sequential successor to the combinational multiply-and-display block.
- Accepts two unsigned W-bit operands on a start/busy/done handshake.
- Multiplies them with a shift-add engine, then converts the 2W-bit product to BCD by double-dabble.
- Drives DIGITS registered active-low 7-segment outputs.
- Sits between board switches/pushbutton logic and the HEX displays; displays hold until the next result.

Parameters:
W, 4, operand width in bits (2..16)
DIGITS, 3, number of 7-segment digits driven; elaboration $error if (2^W-1)^2 > 10^DIGITS-1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
op1  input  W  unsigned multiplicand, captured on accepted start
op2  input  W  unsigned multiplier, captured on accepted start
busy  output  1  high in MUL and BCD states
done  output  1  one-cycle pulse when seg updates
product  output  2W  registered binary product, updated with done
seg  output  DIGITS*7  digit i at [7i+6:7i], i=0 least significant; bit order gfedcba, active low

Behaviour:
- Segment patterns 0-9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0011000; blank = 1111111.
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, product=0, every digit = '0' pattern (see optional feature). Reset mid-operation abandons the computation; outputs return to reset values immediately.
- IDLE: start=1 at an edge captures op1/op2, clears accumulator, goes to MUL. start=0 stays IDLE.
- MUL: exactly W cycles. Each cycle: if multiplier LSB=1, acc += multiplicand (2W-bit, no overflow possible); multiplicand <<1; multiplier >>1. Then go to BCD.
- BCD: exactly 2W cycles of double-dabble on a 4*DIGITS-bit BCD register. Each cycle: add 3 to every nibble >=5, then shift left one bit, taking the product MSB first. Then go to DONE.
- DONE: one cycle. done=1; seg and product registers loaded at the edge entering DONE. Next state IDLE; a start in DONE is ignored.
- Latency: start sampled at edge k -> done high during cycle k+3W+1. For W=4 that is 13 cycles; for W=8, 25 cycles. busy is high for 3W cycles.
- start while busy or in DONE: ignored, no queuing. op1/op2 changes after capture have no effect.
- Minimum issue interval: 3W+2 cycles (start can be re-accepted in the cycle after DONE).
- Zero operand: full latency still applies (no early exit); result 0.
- seg holds its last value indefinitely between operations.

Optional Feature:
LEAD_ZERO_BLANK_EN
- Defined: digits above the most significant non-zero digit show blank (1111111). Digit 0 always shows its value, so 0 displays as a single '0'. At reset, digit 0='0' and all others blank.
- Undefined: all DIGITS digits always show their value, including leading zeros. At reset, all digits = '0'.
- Blanking is computed combinationally from the BCD register and registered into seg on the same edge. It does not add latency.

Decomposition:
- Package seg7_pkg: typedef seg7_t (logic [6:0]); constant array SEG_DIGIT[0:9]; constant SEG_BLANK; enum state_t {IDLE, MUL, BCD, DONE}.
- One sub-module, seg7_decode: 4-bit BCD in, seg7_t out. Codes 10-15 map to SEG_BLANK.
- Instantiate seg7_decode DIGITS times via generate.

Test Plan:
1. W=4, DIGITS=3: op1=15, op2=15, start pulse -> done at cycle 13; product=225; seg digits 2,2,5 = 0100100, 0100100, 0010010.
2. W=4: op1=7, op2=8 -> product=56; digit0=0000010, digit1=0010010; digit2=1111111 with LEAD_ZERO_BLANK_EN, 1000000 without.
3. W=4: op1=0, op2=9 -> done still at cycle 13; product=0; digit0=1000000; upper digits blank or '0' per macro.
4. Start 3=3x3, then pulse start with op1=5, op2=5 at cycles 4 and 13 (DONE) -> both ignored; done only once, product=9; a start accepted at cycle 14 yields 25.
5. Start 12x11, assert rst at cycle 5 (in MUL) -> busy=0, done=0, product=0, seg at reset pattern immediately. After release, 2x3 -> product=6.
6. W=8, DIGITS=5: 255x255 -> done at cycle 25; product=65025; digits 6,5,0,2,5 correct patterns; busy high for exactly 24 cycles.
